div_share_arbiter: RTL and testbench

//  Shares one iterative 16-bit division_processor between NUM_REQ scaling-datapath requesters (e.g. H/V scale-ratio units).

---
 rtl/div_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one iterative divider between NUM_REQ requesters.
// One operation in flight at a time; divide-by-zero is answered locally
// (quotient all-ones, resp_err=1) without starting the divider.
// Optional feature: define DIV_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer register.
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data1,
  input  logic [NUM_REQ*DATA_W-1:0] req_data2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         div_data1,
  output logic [DATA_W-1:0]         div_data2,
  output logic                      div_rdy,
  input  logic [DATA_W-1:0]         div_out,
  input  logic                      div_out_rdy,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] COOL  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] div_data1_q, div_data1_d;
  logic [DATA_W-1:0] div_data2_q, div_data2_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;
`ifdef DIV_ARB_RR_EN
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_d1, sel_d2;

  // Pick the requester to grant this cycle and mux out its operands
  always_comb begin
    int unsigned cand;
    sel_any = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef DIV_ARB_RR_EN
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`else
      cand = k;
`endif
      if (!sel_any && req_valid[IDX_W'(cand)]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
    sel_d1 = '0;
    sel_d2 = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_d1 = req_data1[k*DATA_W +: DATA_W];
        sel_d2 = req_data2[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath capture for the single outstanding operation
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    div_data1_d = div_data1_q;
    div_data2_d = div_data2_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
`ifdef DIV_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_d = sel_idx;
`ifdef DIV_ARB_RR_EN
          rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
`endif
          if (sel_d2 != '0) begin
            div_data1_d = sel_d1;
            div_data2_d = sel_d2;
            err_d       = 1'b0;
            state_d     = ISSUE;
          end else begin
            resp_data_d = '1;
            err_d       = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_out_rdy) begin
          resp_data_d = div_out;
          state_d     = RESP;
        end
      end
      // err_q doubles as the zero-divisor path marker: skip COOL, divider untouched
      RESP:    state_d = err_q ? IDLE : COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      div_data1_q <= '0;
      div_data2_q <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
`ifdef DIV_ARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      div_data1_q <= div_data1_d;
      div_data2_q <= div_data2_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
`ifdef DIV_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // One-hot accept and response strobes decoded from state and grant
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready[k]  = (state_q == IDLE) && sel_any && !reset && (sel_idx == IDX_W'(k));
      resp_valid[k] = (state_q == RESP) && (grant_q == IDX_W'(k));
    end
  end

  assign resp_data = resp_data_q;
  assign resp_err  = (state_q == RESP) && err_q;
  assign div_data1 = div_data1_q;
  assign div_data2 = div_data2_q;
  assign div_rdy   = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter with a behavioural divider of configurable delay.
// Honours DIV_ARB_RR_EN the same way as the design.
module tb_div_share_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data1, req_data2;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_data, div_data1, div_data2, div_out;
  logic           resp_err, div_rdy, div_out_rdy, busy;

  logic [W-1:0] a [N];
  logic [W-1:0] b [N];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr_ptr = 0;

  div_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_data1(req_data1), .req_data2(req_data2),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .div_data1(div_data1), .div_data2(div_data2), .div_rdy(div_rdy),
    .div_out(div_out), .div_out_rdy(div_out_rdy), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    req_data1 = '0;
    req_data2 = '0;
    for (int i = 0; i < N; i++) begin
      req_data1[i*W +: W] = a[i];
      req_data2[i*W +: W] = b[i];
    end
  end

  // Divider model: div_out_rdy in the cycle div_delay after the div_rdy cycle
  int           div_delay = 18;
  int           fire = -1;
  logic         model_rdy = 1'b0;
  logic         spur = 1'b0;
  logic         reset_s = 1'b1;
  logic [W-1:0] mq = '0;
  logic [W-1:0] model_out = '0;

  always @(posedge clk) reset_s <= reset;

  always @(negedge clk) begin
    if (reset_s) begin
      fire      = -1;
      model_rdy = 1'b0;
    end else begin
      model_rdy = (cyc == fire);
      if (div_rdy) begin
        fire = cyc + div_delay;
        mq   = (div_data2 != 0) ? div_data1 / div_data2 : '1;
      end
    end
    model_out = model_rdy ? mq : W'($urandom);
  end

  assign div_out_rdy = model_rdy | spur;
  assign div_out     = spur ? 16'hBEEF : model_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Arbitration rule: first pending requester in search order
  function automatic int model_grant(input logic [N-1:0] v);
    int order[$];
    for (int k = 0; k < N; k++) begin
`ifdef DIV_ARB_RR_EN
      order.push_back((rr_ptr + k) % N);
`else
      order.push_back(k);
`endif
    end
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  // One full transaction starting at a negedge in IDLE with req_valid set
  task automatic txn(input bit hold);
    int g, d;
    logic [N-1:0] oh;
    logic [W-1:0] ea, eb;
    #1;
    g = model_grant(req_valid);
    if (g < 0) begin
      $display("FAIL txn_setup: observed=no request expected=request");
      errors++;
      return;
    end
    oh = N'(1) << g;
    ea = a[g];
    eb = b[g];
    d  = div_delay;
    chk("req_ready", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 0);
    rr_ptr = (g + 1) % N;
    @(negedge clk);
    if (!hold) req_valid[g] = 1'b0;
    if (eb == 0) begin
      chk("zero_resp_valid", 32'(resp_valid), 32'(oh));
      chk("zero_resp_data", 32'(resp_data), 32'hFFFF);
      chk("zero_resp_err", 32'(resp_err), 1);
      chk("zero_no_div_rdy", 32'(div_rdy), 0);
      chk("zero_ready_low", 32'(req_ready), 0);
      @(negedge clk);
    end else begin
      chk("issue_div_rdy", 32'(div_rdy), 1);
      chk("issue_data1", 32'(div_data1), 32'(ea));
      chk("issue_data2", 32'(div_data2), 32'(eb));
      chk("issue_ready_low", 32'(req_ready), 0);
      repeat (d) begin
        @(negedge clk);
        chk("wait_no_resp", 32'(resp_valid), 0);
        chk("wait_no_div_rdy", 32'(div_rdy), 0);
        chk("wait_data1", 32'(div_data1), 32'(ea));
        chk("wait_data2", 32'(div_data2), 32'(eb));
        chk("wait_busy", 32'(busy), 1);
      end
      @(negedge clk);
      chk("resp_valid", 32'(resp_valid), 32'(oh));
      chk("resp_data", 32'(resp_data), 32'(ea / eb));
      chk("resp_err", 32'(resp_err), 0);
      @(negedge clk);
      chk("cool_busy", 32'(busy), 1);
      chk("cool_no_div_rdy", 32'(div_rdy), 0);
      chk("cool_ready_low", 32'(req_ready), 0);
      chk("cool_no_resp", 32'(resp_valid), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end

    // Reset state, with requests present to confirm req_ready is held low
    req_valid = '1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_div_rdy", 32'(div_rdy), 0);
    chk("rst_div_data1", 32'(div_data1), 0);
    chk("rst_div_data2", 32'(div_data2), 0);
    req_valid = '0;
    reset = 1'b0;
    @(negedge clk);

    // Single request 100/7 with an 18-cycle divider
    a[0] = 16'd100; b[0] = 16'd7; div_delay = 18;
    req_valid = 4'b0001;
    txn(1'b0);

    // Zero divisor on requester 1
    a[1] = 16'd5; b[1] = 16'd0;
    req_valid = 4'b0010;
    txn(1'b0);

    // Spurious divider strobe while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_no_resp", 32'(resp_valid), 0);
    chk("spur_idle", 32'(busy), 0);
    @(negedge clk);
    chk("spur_no_resp2", 32'(resp_valid), 0);
    a[2] = 16'd60; b[2] = 16'd6; div_delay = 7;
    req_valid = 4'b0100;
    txn(1'b0);

    // All requesters held continuously
    for (int i = 0; i < N; i++) begin a[i] = W'(1000 + 37 * i); b[i] = W'(i + 3); end
    div_delay = 3;
    req_valid = '1;
    repeat (5) txn(1'b1);
    req_valid = '0;
    @(negedge clk);

    // Reset while waiting on the divider for requester 3
    a[3] = 16'd900; b[3] = 16'd3; div_delay = 15;
    req_valid = 4'b1000;
    #1;
    g = model_grant(req_valid);
    chk("r5_accept", 32'(req_ready), 32'(N'(1) << g));
    @(negedge clk);
    chk("r5_issue", 32'(div_rdy), 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rr_ptr = 0;
    chk("r5_busy", 32'(busy), 0);
    chk("r5_ready", 32'(req_ready), 0);
    chk("r5_resp_valid", 32'(resp_valid), 0);
    chk("r5_resp_data", 32'(resp_data), 0);
    chk("r5_resp_err", 32'(resp_err), 0);
    chk("r5_div_rdy", 32'(div_rdy), 0);
    chk("r5_div_data1", 32'(div_data1), 0);
    chk("r5_div_data2", 32'(div_data2), 0);
    reset = 1'b0;
    req_valid = '0;
    repeat (20) begin
      @(negedge clk);
      chk("r5_dropped", 32'(resp_valid), 0);
      chk("r5_idle", 32'(busy), 0);
    end
    div_delay = 4;
    req_valid = 4'b1000;
    txn(1'b0);

    // Back-to-back requests from 0 and 1
    a[0] = 16'd4000; b[0] = 16'd9; a[1] = 16'd65535; b[1] = 16'd1;
    div_delay = 1;
    req_valid = 4'b0011;
    txn(1'b0);
    txn(1'b0);

    // Randomised traffic: pending requests stay asserted until granted
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          a[i] = W'($urandom);
          b[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 65535));
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        a[0] = W'($urandom);
        b[0] = W'($urandom_range(1, 300));
        req_valid[0] = 1'b1;
      end
      div_delay = $urandom_range(1, 12);
      txn(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
